// File: rtl/fp16_to_int16_converter_if.sv
// -----------------------------------------------------------------------------
// fp16_to_int16_converter_if
// Handshake bundle between the FP result bus, the fp16 -> int16 converter and
// the integer writeback.
//   x         fp16 operand {sign, exp[4:0], mant[9:0]}
//   in_valid  operand present
//   in_ready  converter can accept an operand
//   r         signed 16-bit integer result
//   out_valid result and flags valid
//   out_ready consumer accepts the result
//   invalid   NaN, infinity or out-of-range operand (result saturated)
//   inexact   a nonzero fraction was discarded by rounding
// The converter uses the slave modport; the producer/consumer side uses master.
// -----------------------------------------------------------------------------
interface fp16_to_int16_converter_if;
    logic        [15:0] x;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] r;
    logic               out_valid;
    logic               out_ready;
    logic               invalid;
    logic               inexact;

    modport slave (
        input  x, in_valid, out_ready,
        output in_ready, r, out_valid, invalid, inexact
    );

    modport master (
        output x, in_valid, out_ready,
        input  in_ready, r, out_valid, invalid, inexact
    );
endinterface

// File: rtl/fp16_to_int16_converter.sv
// -----------------------------------------------------------------------------
// fp16_to_int16_converter
// Iterative half-precision float to 16-bit two's-complement integer converter
// with round-to-nearest-even. One shift bit per cycle keeps the datapath small.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fp16_to_int16_converter_if.slave (x/in_valid/in_ready on the input
//          side, r/out_valid/out_ready/invalid/inexact on the output side)
// Parameters:
//   MAX_RSHIFT  cap on right-shift iterations (beyond it only sticky would
//               change, and the magnitude is already zero); must be <= 31.
// -----------------------------------------------------------------------------
module fp16_to_int16_converter #(
    parameter int MAX_RSHIFT = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    fp16_to_int16_converter_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [4:0] RSHIFT_CAP = 5'(MAX_RSHIFT);
    // Exponent at which the 11-bit significand {1,mant} is already an integer.
    localparam logic [4:0] UNITY_EXP  = 5'd25;

    state_t             state;
    logic        [15:0] mag;
    logic               guard;
    logic               sticky;
    logic               sign;
    logic               shift_left;
    logic        [4:0]  cnt;
    logic signed [15:0] r_q;
    logic               out_valid_q;
    logic               invalid_q;
    logic               inexact_q;

    logic        [4:0]  x_exp;
    logic        [9:0]  x_mant;
    logic        [4:0]  rshift_raw;

    assign x_exp      = bus.x[14:10];
    assign x_mant     = bus.x[9:0];
    assign rshift_raw = UNITY_EXP - x_exp;

    // Round-to-nearest-even increment of the shifted magnitude.
    function automatic logic [15:0] round_rne(input logic [15:0] m,
                                              input logic        g,
                                              input logic        s);
        return m + {15'd0, g & (s | m[0])};
    endfunction

    // Saturated result for out-of-range operands of the given sign.
    function automatic logic signed [15:0] saturate(input logic neg);
        return neg ? 16'sh8000 : 16'sh7FFF;
    endfunction

    // Magnitude is always < 2^15 here, so negation cannot wrap.
    function automatic logic signed [15:0] apply_sign(input logic        neg,
                                                      input logic [15:0] m);
        return neg ? -signed'(m) : signed'(m);
    endfunction

    assign bus.in_ready  = (state == IDLE);
    assign bus.r         = r_q;
    assign bus.out_valid = out_valid_q;
    assign bus.invalid   = invalid_q;
    assign bus.inexact   = inexact_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mag         <= '0;
            guard       <= 1'b0;
            sticky      <= 1'b0;
            sign        <= 1'b0;
            shift_left  <= 1'b0;
            cnt         <= '0;
            r_q         <= '0;
            out_valid_q <= 1'b0;
            invalid_q   <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign   <= bus.x[15];
                        mag    <= {5'd0, 1'b1, x_mant};
                        guard  <= 1'b0;
                        sticky <= 1'b0;
                        if (x_exp == 5'd31) begin
                            // NaN saturates positive; infinities follow their sign.
                            r_q         <= (x_mant != 10'd0) ? 16'sh7FFF : saturate(bus.x[15]);
                            invalid_q   <= 1'b1;
                            inexact_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else if (x_exp == 5'd30) begin
                            // -32768 is the only representable value in this binade.
                            r_q         <= saturate(bus.x[15]);
                            invalid_q   <= !(bus.x[15] && (x_mant == 10'd0));
                            inexact_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else if (x_exp == 5'd0) begin
                            r_q         <= '0;
                            invalid_q   <= 1'b0;
                            inexact_q   <= (x_mant != 10'd0);
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else if (x_exp == UNITY_EXP) begin
                            shift_left <= 1'b0;
                            cnt        <= '0;
                            state      <= ROUND;
                        end else if (x_exp > UNITY_EXP) begin
                            shift_left <= 1'b1;
                            cnt        <= x_exp - UNITY_EXP;
                            state      <= SHIFT;
                        end else begin
                            shift_left <= 1'b0;
                            cnt        <= (rshift_raw > RSHIFT_CAP) ? RSHIFT_CAP : rshift_raw;
                            state      <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    if (shift_left) begin
                        mag <= {mag[14:0], 1'b0};
                    end else begin
                        sticky <= sticky | guard;
                        guard  <= mag[0];
                        mag    <= {1'b0, mag[15:1]};
                    end
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state <= ROUND;
                    end
                end

                ROUND: begin
                    mag         <= round_rne(mag, guard, sticky);
                    r_q         <= apply_sign(sign, round_rne(mag, guard, sticky));
                    inexact_q   <= guard | sticky;
                    invalid_q   <= 1'b0;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end

                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        invalid_q   <= 1'b0;
                        inexact_q   <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
